mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port main-memory BRAM between the I-cache and D-cache refill/writeback
//  engines. Grants whole bursts (writeback or allocate) to one requester at a time,
//  round-robin between simultaneous requesters. Routes the 1-cycle-latency read data back
//  to the owner with an rvalid strobe. Guards against a requester holding the port forever.
// PARAMETERS
//  ADDR_W     32  address width
//  DATA_W     32  data width per beat
//  MAX_BEATS  4   max accepted beats per grant before forced release
// PORTS
//  clk         in   1       clock
//  rst         in   1       async reset, active-high
//  i_req       in   1       I-side beat request (held for whole burst)
//  i_last      in   1       I-side final beat of burst
//  i_we        in   1       I-side write beat
//  i_addr      in   ADDR_W  I-side beat address
//  i_wdata     in   DATA_W  I-side write data
//  i_type      in   2       I-side access type (00 byte, 01 half, 10 word)
//  i_gnt       out  1       I-side owns port; beat accepted when i_req&&i_gnt
//  i_rvalid    out  1       rdata valid for I-side read beat accepted last cycle
//  d_*         --   --      identical set for D-side (d_req..d_type, d_gnt, d_rvalid)
//  rdata       out  DATA_W  registered-through copy of mem_rdata, shared by both sides
//  mem_en      out  1       beat issued to memory this cycle
//  mem_we      out  1       write enable
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_type    out  2       access type
//  mem_rdata   in   DATA_W  memory read data, valid 1 cycle after read beat
//  err_timeout out  1       sticky: a grant was force-released
// BEHAVIOUR
//  Reset: state IDLE; i_gnt=d_gnt=0; i_rvalid=d_rvalid=0; err_timeout=0; beat_cnt=0;
//   rr_last=I (D wins first tie). Reset mid-burst aborts the burst; no pending rvalid.
//  FSM IDLE / OWN_I / OWN_D. x_gnt is registered: x_gnt = (state==OWN_x).
//   IDLE: one req -> OWN_that next cycle; both -> owner != rr_last; none -> stay.
//   OWN_x: each cycle with x_req accepted beat, beat_cnt++. Release when: accepted beat with
//    x_last; or x_req low (abort); or beat_cnt reaches MAX_BEATS without last (set err_timeout).
//   On release rr_last<=x; next state = OWN_other if other req high that cycle, else IDLE
//    (back-to-back handoff, zero bubble). beat_cnt cleared on every grant change.
//  Latency: req in IDLE at cycle N -> gnt at N+1 -> first beat accepted N+1.
//  mem_en = owner_req && owner_gnt; mem_addr/wdata/we/type muxed from owner; all zero when
//   mem_en=0 (no writes ever leak from the non-owner).
//  Read return: flop {mem_en&&!mem_we, owner} -> x_rvalid pulses next cycle for that owner
//   only; rdata = mem_rdata. Survives handoff (rvalid of old owner may coincide with new gnt).
//  beat_cnt width $clog2(MAX_BEATS+1); never wraps (release precedes overflow).
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds outputs stat_i_bursts, stat_d_bursts, stat_wait_cycles
//   (32-bit each, reset 0, saturate at all-ones). bursts++ on each grant start; wait++ each
//   cycle a req is high while that side lacks gnt. Undefined: ports and logic absent.
// STRUCTURE
//  mem_arb_pkg: arb_state_t {IDLE,OWN_I,OWN_D}, owner_t {OWN_NONE,OWN_ICACHE,OWN_DCACHE},
//   ACCESS_WORD=2'b10 constants shared with cache controllers.
//  Sub-module mem_arb_stats (counters only), instantiated under MEM_ARB_STATS_EN.
// TESTING
//  1 Single D burst: d_req 4 beats, addr 0x100..0x10C, last on 4th -> d_gnt 1 cycle after
//    req, 4 mem_en beats, d_rvalid on cycles 2-5 with BRAM contents, d_gnt drops after.
//  2 Tie: i_req,d_req same cycle from reset -> D granted first, then I with zero bubble;
//    next tie -> I first (round-robin alternates).
//  3 D writeback 4 beats then allocate while I requests -> I served between the two D bursts;
//    no I write/addr on mem_* during D grant.
//  4 Timeout: i_req held, i_last never -> release after 4 beats, err_timeout=1 and stays 1.
//  5 Abort: d_req drops after beat 2 -> d_gnt low next cycle, pending I granted; rvalid for
//    beat 2 still delivered to D only.
//  6 Reset asserted mid-burst -> gnt/rvalid/err 0 immediately; post-reset tie grants D.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and access-size encodings for the main-memory arbiter and the cache controllers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_ICACHE = 2'd1,
        OWN_DCACHE = 2'd2
    } owner_t;

    localparam logic [1:0] ACCESS_BYTE = 2'b00;
    localparam logic [1:0] ACCESS_HALF = 2'b01;
    localparam logic [1:0] ACCESS_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating burst and wait-cycle counters for the memory arbiter (built only with MEM_ARB_STATS_EN).
module mem_arb_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        d_start,
    input  logic        i_wait,
    input  logic        d_wait,
    output logic [31:0] stat_i_bursts,
    output logic [31:0] stat_d_bursts,
    output logic [31:0] stat_wait_cycles
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF))
            return v + 32'd1;
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_i_bursts    <= '0;
            stat_d_bursts    <= '0;
            stat_wait_cycles <= '0;
        end else begin
            stat_i_bursts    <= sat_inc(stat_i_bursts, i_start);
            stat_d_bursts    <= sat_inc(stat_d_bursts, d_start);
            stat_wait_cycles <= sat_inc(stat_wait_cycles, i_wait || d_wait);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Burst-granular round-robin arbiter sharing one BRAM port between I- and D-cache engines.
// Optional statistics counters are enabled with `define MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_last,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_type,
    output logic              i_gnt,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic              d_last,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_type,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_type,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_timeout
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_i_bursts,
    output logic [31:0]       stat_d_bursts,
    output logic [31:0]       stat_wait_cycles
`endif
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_t       state, state_nxt;
    owner_t           rr_last, rr_last_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic             err_nxt;
    logic             own_req, own_last, other_req, at_cap;
    logic             rd_vld_p1;
    owner_t           rd_own_p1;

    assign own_req   = (state == OWN_I) ? i_req  : (state == OWN_D) ? d_req  : 1'b0;
    assign own_last  = (state == OWN_I) ? i_last : (state == OWN_D) ? d_last : 1'b0;
    assign other_req = (state == OWN_I) ? d_req  : i_req;
    assign at_cap    = (beat_cnt == CNT_W'(MAX_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_last     <= OWN_ICACHE;
            beat_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_last     <= rr_last_nxt;
            beat_cnt    <= beat_cnt_nxt;
            err_timeout <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_last_nxt  = rr_last;
        beat_cnt_nxt = beat_cnt;
        err_nxt      = err_timeout;
        case (state)
            IDLE: begin
                if (i_req && d_req)
                    state_nxt = (rr_last == OWN_ICACHE) ? OWN_D : OWN_I;
                else if (i_req)
                    state_nxt = OWN_I;
                else if (d_req)
                    state_nxt = OWN_D;
            end
            OWN_I, OWN_D: begin
                if (own_req)
                    beat_cnt_nxt = beat_cnt + 1'b1;
                // Release on last beat, abort, or reaching the beat cap without a last.
                if (!own_req || own_last || at_cap) begin
                    rr_last_nxt  = (state == OWN_I) ? OWN_ICACHE : OWN_DCACHE;
                    beat_cnt_nxt = '0;
                    if (own_req && !own_last)
                        err_nxt = 1'b1;
                    if (other_req)
                        state_nxt = (state == OWN_I) ? OWN_D : OWN_I;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_gnt     = (state == OWN_I);
        d_gnt     = (state == OWN_D);
        mem_en    = own_req;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_type  = '0;
        if (own_req) begin
            if (state == OWN_I) begin
                mem_we    = i_we;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                mem_type  = i_type;
            end else begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_type  = d_type;
            end
        end
    end

    // p1: read beat issued last cycle; data returns from the BRAM now
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_vld_p1 <= 1'b0;
        else
            rd_vld_p1 <= mem_en && !mem_we;
    end

    always_ff @(posedge clk) begin
        rd_own_p1 <= (state == OWN_I) ? OWN_ICACHE : OWN_DCACHE;
    end

    assign i_rvalid = rd_vld_p1 && (rd_own_p1 == OWN_ICACHE);
    assign d_rvalid = rd_vld_p1 && (rd_own_p1 == OWN_DCACHE);
    assign rdata    = mem_rdata;

`ifdef MEM_ARB_STATS_EN
    logic i_start, d_start;

    assign i_start = (state_nxt == OWN_I) && (state != OWN_I);
    assign d_start = (state_nxt == OWN_D) && (state != OWN_D);

    mem_arb_stats u_stats (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .d_start          (d_start),
        .i_wait           (i_req && !i_gnt),
        .d_wait           (d_req && !d_gnt),
        .stat_i_bursts    (stat_i_bursts),
        .stat_d_bursts    (stat_d_bursts),
        .stat_wait_cycles (stat_wait_cycles)
    );
`endif

endmodule
